// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port, fixed-latency memory between
// the instruction-fetch port and the data-memory port, and drives the pipeline stall.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       FETCH = 1'b0;
    localparam logic       DATA  = 1'b1;
    localparam logic [3:0] LAT   = 4'(MEM_LAT);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       grant_sel, last_grant, win, grant, capture;
    logic       mem_en_d, busy_d, if_ready_d, dm_ready_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // On a tie the port that did not win last time takes the memory.
    always_comb begin
        win = FETCH;
        if (if_req && dm_req) win = ~last_grant;
        else if (dm_req)      win = DATA;
    end

    assign grant   = (state == IDLE) && (if_req || dm_req);
    assign capture = (state == WAIT) && (cnt == 4'd1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (capture) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so that they can be registered.
    always_comb begin
        mem_en_d   = (next_state == ISSUE);
        busy_d     = (next_state != IDLE);
        if_ready_d = (next_state == RESP) && (grant_sel == FETCH);
        dm_ready_d = (next_state == RESP) && (grant_sel == DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            cnt        <= '0;
            grant_sel  <= FETCH;
            last_grant <= FETCH;
        end else begin
            mem_en   <= mem_en_d;
            busy     <= busy_d;
            if_ready <= if_ready_d;
            dm_ready <= dm_ready_d;
            if (grant) begin
                grant_sel  <= win;
                last_grant <= win;
                mem_addr   <= (win == DATA) ? dm_addr : if_addr;
                mem_we     <= (win == DATA) && dm_we;
                if (win == DATA) mem_wdata <= dm_wdata;
            end
            if (state == ISSUE)     cnt <= LAT;
            else if (state == WAIT) cnt <= cnt - 4'd1;
            // Stores capture too; the requester ignores dm_rdata on a store.
            if (capture) begin
                if (grant_sel == FETCH) if_rdata <= mem_rdata;
                else                    dm_rdata <= mem_rdata;
            end
        end
    end

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter, with extra MEM_LAT=1/15 instances.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clk, rst;
    logic        if_req, if_ready, dm_req, dm_we, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, stall, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct { int c; logic [31:0] addr; logic we; logic [31:0] wd; } mexp_t;
    typedef struct { int c; logic [31:0] d; bit chkd; } rexp_t;
    typedef struct { int c; logic [31:0] d; } rd_t;
    mexp_t mq[$];
    rexp_t rq_if[$], rq_dm[$];
    rd_t   rdq[$];
    logic [31:0] env_mem[int];
    logic [31:0] ref_mem[int];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
    );

    // Extra fetch-only instances at the latency extremes.
    logic        x_req[2], x_ifr[2], x_dmr[2], x_men[2], x_mwe[2], x_stall[2], x_busy[2];
    logic [31:0] x_mrd[2], x_ifrd[2], x_dmrd[2], x_maddr[2], x_mwd[2];
    int          x_en[2], x_t[2];
    bit          x_done[2];

    for (genvar g = 0; g < 2; g++) begin : gx
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 15)) u (
            .clk(clk), .rst(rst),
            .if_req(x_req[g]), .if_addr(32'h40), .if_rdata(x_ifrd[g]), .if_ready(x_ifr[g]),
            .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
            .dm_rdata(x_dmrd[g]), .dm_ready(x_dmr[g]),
            .mem_en(x_men[g]), .mem_we(x_mwe[g]), .mem_addr(x_maddr[g]), .mem_wdata(x_mwd[g]),
            .mem_rdata(x_mrd[g]), .stall(x_stall[g]), .busy(x_busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2010_0005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : rom(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : rom(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory environment: fixed latency, random junk on every other cycle.
    always @(negedge clk) begin
        if (rst && mem_en) begin
            rdq.push_back('{cyc + L, env_rd(mem_addr)});
            if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
        end
        for (int i = 0; i < 2; i++) if (rst && x_men[i]) x_en[i] = cyc;
    end
    always @(posedge clk) begin
        #1;
        while (rdq.size() != 0 && rdq[0].c < cyc) void'(rdq.pop_front());
        if (rdq.size() != 0 && rdq[0].c == cyc) mem_rdata = rdq.pop_front().d;
        else mem_rdata = $urandom;
        for (int i = 0; i < 2; i++)
            x_mrd[i] = (cyc == x_en[i] + (i == 0 ? 1 : 15)) ? (32'hC0DE_0000 + 32'(i)) : $urandom;
    end

    // Reference model: a shared resource that is free again MEM_LAT+3 cycles after a grant.
    int   free_at = 0, busy_from = 0, rsp_c[2] = '{-1, -1};
    logic lastg = 1'b0, w;
    always @(negedge clk) begin
        if (!rst) begin
            free_at = 0; busy_from = 0; rsp_c[0] = -1; rsp_c[1] = -1; lastg = 1'b0;
            mq.delete(); rq_if.delete(); rq_dm.delete();
        end else begin
            chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < free_at));
            chk("stall", 32'(stall), 32'((if_req && rsp_c[0] != cyc) || (dm_req && rsp_c[1] != cyc)));
            if (cyc >= free_at && (if_req || dm_req)) begin
                w = (if_req && dm_req) ? ~lastg : dm_req;
                lastg = w;
                busy_from = cyc + 1;
                free_at = cyc + 3 + L;
                if (w) begin
                    rsp_c[1] = cyc + 2 + L;
                    mq.push_back('{cyc + 1, dm_addr, dm_we, dm_wdata});
                    rq_dm.push_back('{cyc + 2 + L, ref_rd(dm_addr), !dm_we});
                    if (dm_we) ref_mem[int'(dm_addr)] = dm_wdata;
                end else begin
                    rsp_c[0] = cyc + 2 + L;
                    mq.push_back('{cyc + 1, if_addr, 1'b0, 32'h0});
                    rq_if.push_back('{cyc + 2 + L, ref_rd(if_addr), 1'b1});
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an access or a response.
    mexp_t m;
    rexp_t r;
    always @(negedge clk) begin
        if (rst) begin
            if (mem_en) begin
                chk("mem_en_expected", 32'(mq.size() != 0), 32'd1);
                if (mq.size() != 0) begin
                    m = mq.pop_front();
                    chk("mem_en_cycle", cyc, m.c);
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    if (m.we) chk("mem_wdata", mem_wdata, m.wd);
                end
            end
            if (if_ready) begin
                chk("if_ready_expected", 32'(rq_if.size() != 0), 32'd1);
                if (rq_if.size() != 0) begin
                    r = rq_if.pop_front();
                    chk("if_ready_cycle", cyc, r.c);
                    chk("if_rdata", if_rdata, r.d);
                end
            end
            if (dm_ready) begin
                chk("dm_ready_expected", 32'(rq_dm.size() != 0), 32'd1);
                if (rq_dm.size() != 0) begin
                    r = rq_dm.pop_front();
                    chk("dm_ready_cycle", cyc, r.c);
                    if (r.chkd) chk("dm_rdata", dm_rdata, r.d);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (x_men[i] && i == 0) x_req[0] = 1'b0;   // dropped before ready on purpose
                if (x_ifr[i]) begin
                    chk("x_single_ready", 32'(x_done[i]), 32'd0);
                    chk("x_ready_cycle", cyc, x_t[i] + 2 + (i == 0 ? 1 : 15));
                    chk("x_rdata", x_ifrd[i], 32'hC0DE_0000 + 32'(i));
                    x_done[i] = 1'b1;
                    x_req[i] = 1'b0;
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        if_req = 1'b1; if_addr = a;
        @(negedge clk);
        while (!if_ready && n < 100) begin @(negedge clk); n++; end
        chk("if_ready_seen", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        @(negedge clk);
        while (!dm_ready && n < 100) begin @(negedge clk); n++; end
        chk("dm_ready_seen", 32'(dm_ready), 32'd1);
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin x_req[i] = 1'b0; x_en[i] = -100; x_done[i] = 1'b0; x_mrd[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin x_req[i] = 1'b1; x_t[i] = cyc; end

        do_fetch(32'h40);
        do_data(1'b1, 32'h80, 32'hDEAD_BEEF);
        do_fetch(32'h0);
        do_fetch(32'h4);
        do_fetch(32'h8);

        // Reset while the access is in WAIT; the memory still answers later.
        env_mem[32'h100] = 32'h1234_5678;
        ref_mem[32'h100] = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        if_req = 1'b0;
        chk("rst_wait_mem_en", 32'(mem_en), 32'd0);
        chk("rst_wait_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wait_mem_addr", mem_addr, 32'd0);
        chk("rst_wait_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wait_if_ready", 32'(if_ready), 32'd0);
        chk("rst_wait_dm_ready", 32'(dm_ready), 32'd0);
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_if_rdata", if_rdata, 32'd0);
        chk("rst_wait_dm_rdata", dm_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Tie straight out of reset: data first, fetch one occupancy later.
        fork
            do_data(1'b0, 32'h80, 32'h0);
            do_fetch(32'h100);
        join

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    do_fetch(32'($urandom_range(0, 47)) * 4);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    idle($urandom_range(0, 3));
                    do_data(1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 15)) * 4, $urandom);
                end
            end
        join

        repeat (8) @(negedge clk);
        chk("mem_queue_drained", mq.size(), 0);
        chk("if_queue_drained", rq_if.size(), 0);
        chk("dm_queue_drained", rq_dm.size(), 0);
        chk("x_l1_done", 32'(x_done[0]), 32'd1);
        chk("x_l15_done", 32'(x_done[1]), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port and data-memory port. Grants one access at a time with round-robin priority and launches the access. Returns read data with a one-cycle ready pulse to the winning port and drives the pipeline-wide stall. Sits between the fetch/mem stages of the CPU core and the unified memory model in the top level.

## Interface
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data (loads and stores).
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address, qualified by mem_en.
- mem_wdata  out  DATA_W  memory write data, qualified by mem_en.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- stall  out  1  pipeline stall.
- busy  out  1  1 whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled at each rising edge.
  - Only one port is requesting: that port is granted.
  - Both are requesting: the port not granted last time wins.
  - last_grant resets to FETCH, so data wins the first tie.
  - On a grant: address, we and wdata are latched, grant_sel and last_grant are updated, and the FSM moves to ISSUE.
- ISSUE: registered mem_en=1, mem_we=latched we (0 for fetch), mem_addr/mem_wdata = latched values. Wait counter loads MEM_LAT. Next state is WAIT.
- WAIT: the counter decrements each cycle.
  - On the cycle mem_rdata is valid (MEM_LAT cycles after ISSUE), mem_rdata is captured into the response register and the FSM moves to RESP.
  - Stores also wait the full MEM_LAT; the captured value is ignored.
- RESP: the ready pulse of the granted port is 1; the corresponding rdata shows the captured word. Requests are NOT sampled in RESP, because requester inputs are still the old request. Next state is IDLE.
- The non-granted port's ready is always 0. The non-granted port's rdata holds its last value.
- stall = (if_req & ~if_ready) | (dm_req & ~dm_ready). It is combinational from the inputs and registered ready.
- mem_addr/mem_wdata/mem_we hold their last values when mem_en=0. Only mem_en qualifies them.
- Request dropped before ready (protocol violation): the access still completes and ready still pulses; no abort.
- Reset (asynchronous, any state): state=IDLE, last_grant=FETCH, counter=0. mem_en, mem_we, if_ready, dm_ready and busy go to 0. mem_addr, mem_wdata, if_rdata and dm_rdata go to 0. An in-flight memory read is discarded; the first post-reset grant starts a fresh access.

## Timing
- Request high in IDLE at cycle t:
  - mem_en in cycle t+1.
  - mem_rdata sampled at the end of cycle t+1+MEM_LAT.
  - Ready pulse in cycle t+2+MEM_LAT.
  - Back in IDLE at t+3+MEM_LAT.
- Per-access occupancy is MEM_LAT+3 cycles. Back-to-back accesses are spaced MEM_LAT+3 cycles apart, mem_en to mem_en.
- All outputs are registered except stall.
- No combinational path from mem_rdata to any output.

## Test plan
- Reset then hold if_req=1, if_addr=0x0000_0040, MEM_LAT=2, with the memory returning 0x2010_0005 -> mem_en=1/mem_we=0/mem_addr=0x40 in cycle 1. Then if_ready=1 with if_rdata=0x2010_0005 in cycle 4. stall=1 in cycles 0-3 and 0 in cycle 4.
- Store: dm_req=1, dm_we=1, dm_addr=0x80, dm_wdata=0xDEAD_BEEF -> one mem_en cycle with mem_we=1 and those values. dm_ready pulses once after 3 further cycles; if_ready stays 0.
- if_req and dm_req both asserted from reset -> data is granted first. Fetch mem_en follows 5 cycles after the data mem_en. When both are re-requested afterwards, grants alternate DATA, FETCH, DATA, with no port starved.
- Three sequential fetches with the requester advancing its address on each if_ready -> exactly one mem_en per address (0x0, 0x4, 0x8). No duplicate access for the stale request in RESP.
- Reset asserted during WAIT, with the memory later returning 0x1234_5678 -> all outputs 0 immediately. No ready pulse for the aborted access; the next request completes normally with fresh data.
- MEM_LAT=1 and MEM_LAT=15 builds -> ready arrives at t+3 and t+17 respectively, with correct data.
